erode_disp: RTL
===============

// Module: erode_disp
// PURPOSE
//   3x3 binary erosion on a 16-bit pixel stream; the dual of the dilation stage.
//   Contains its own two-line buffer and 3x3 window, so it needs no external matrix block.
//   Sits after binarisation and before dilation, forming an opening (erode then dilate)
//   that removes speckle from the ball mask.
//   Sync/enable signals pass through with the same fixed latency as the data.
// PARAMETERS
//   IMG_W   640  max active pixels per line (line buffer depth)
//   CNT_W   11   width of column/row counters; 2^CNT_W > IMG_W required
// PORTS
//   clk            in   1   pixel clock
//   rst_n          in   1   asynchronous active-low reset
//   vsync_i        in   1   frame sync, active high; frame starts on its rising edge
//   hsync_i        in   1   line sync, delay-matched only
//   data_en_i      in   1   pixel valid, high for the active part of each line
//   bin_data_i     in   16  binary pixel: foreground iff bin_data_i != 16'h0000
//   vsync_o        out  1   vsync_i delayed 3 clk
//   hsync_o        out  1   hsync_i delayed 3 clk
//   data_en_o      out  1   data_en_i delayed 3 clk
//   erode_data_o   out  16  16'hFFFF = foreground, 16'h0000 = background
// BEHAVIOUR
//   Reset: all pipeline, window and counter registers are 0.
//     All outputs are 0, col = 0, row = 0.
//   Counters:
//     - col increments on each clk with data_en_i = 1; it clears on the clk after data_en_i falls.
//     - row increments on each falling edge of data_en_i (end of line).
//     - row clears on vsync_i rising edge, detected from a 1-clk registered copy of vsync_i.
//     - If vsync rises while data_en_i = 1, that pixel counts as row 0.
//     - row saturates at 2^CNT_W-1; it never wraps.
//   Line buffers: two 1-bit x IMG_W memories, LB1 = previous row, LB2 = row before that.
//     - On data_en_i with col < IMG_W: read both at address col (old data),
//       then write LB2[col] <= LB1[col] and LB1[col] <= fg(bin_data_i).
//     - Columns col >= IMG_W do not write the buffers and produce output 0.
//   Window: 3x3 register array, shifted by one column on each data_en_i.
//     - New right column = {LB2[col], LB1[col], fg(in)}.
//     - Window W(r,c) = pixels p(r-2..r, c-2..c); the window holds when data_en_i = 0.
//   Pipeline (latency exactly 3 clk, input slot -> output slot):
//     - S1: window/column shift and capture of (r >= 2 && c >= 2 && c < IMG_W) as valid_win.
//     - S2: three row-ANDs plus valid_win.
//     - S3: final AND, registered as erode.
//   Output: erode_data_o = (erode && data_en_o) ? 16'hFFFF : 16'h0000.
//     - The output image is shifted by one row and one column relative to the input (window centre).
//   Border: any window that is not fully inside the frame (r < 2 or c < 2) outputs 0.
//     No data from a previous frame or line is used.
//   Frame boundary: stale line-buffer contents are never used, because row < 2 gates the output.
//     The buffers need no clearing.
//   Blanking: pixels outside data_en_i are ignored.
//     The hsync/vsync delay lines shift every clk regardless of data_en_i.
//   Reset mid-frame: the block restarts at row 0, col 0.
//     The remainder of that frame may be mis-aligned.
//     Output is exact from the next vsync_i rising edge.
// TESTING
//   (bench IMG_W=8, frames 8x6, 2 clk blanking between lines)
//   1. All-0xFFFF frame:
//      data_en_o pixels at rows 0-1 or cols 0-1 -> 0; all others -> 16'hFFFF.
//   2. All-zero frame: every erode_data_o = 0.
//      vsync_o/hsync_o/data_en_o equal the inputs delayed by exactly 3 clk.
//   3. Single 0x0000 pixel at (3,4) in an all-ones frame:
//      output zeros at window positions r 3..5 x c 4..6; all other interior positions -> 0xFFFF.
//   4. Isolated 2x2 foreground blob in a zero frame: output all 0 (the blob is fully eroded).
//   5. Two consecutive frames, the first all-ones and the second with rows 0-1 zero:
//      row 2 of the second frame outputs 0, proving no stale buffer data is used.
//   6. Reset asserted mid-line, then a full frame: all outputs 0 during reset;
//      the next frame matches scenario 1 exactly.

Source files
------------

// File: rtl/erode_if.sv
// Pixel-stream bundle for the 3x3 erosion stage.
// slave = erosion block, master = upstream source / downstream sink.
interface erode_if;
    logic        vsync_i;
    logic        hsync_i;
    logic        data_en_i;
    logic [15:0] bin_data_i;
    logic        vsync_o;
    logic        hsync_o;
    logic        data_en_o;
    logic [15:0] erode_data_o;

    modport slave (
        input  vsync_i, hsync_i, data_en_i, bin_data_i,
        output vsync_o, hsync_o, data_en_o, erode_data_o
    );

    modport master (
        output vsync_i, hsync_i, data_en_i, bin_data_i,
        input  vsync_o, hsync_o, data_en_o, erode_data_o
    );
endinterface

// File: rtl/erode_disp.sv
// 3x3 binary erosion with internal two-line buffer and window.
// Fixed 3-clk latency; sync/enable delay-matched to the data.
module erode_disp #(
    parameter int IMG_W = 640,
    parameter int CNT_W = 11
) (
    input  logic   clk,
    input  logic   rst_n,
    erode_if.slave bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic             vs_d, de_d;
    logic [CNT_W-1:0] col, row;
    logic [IMG_W-1:0] lb1, lb2;
    logic [2:0][2:0]  win;
    logic             valid_win;
    logic [2:0]       and_q;
    logic             v2, erode;
    logic [2:0]       vs_p, hs_p, de_p;

    logic             vs_rise, de_fall, in_rng, fg;
    logic [CNT_W-1:0] row_cur;
    logic [AW-1:0]    addr;
    logic [2:0]       ncol;

    always_comb begin
        vs_rise = bus.vsync_i & ~vs_d;
        de_fall = de_d & ~bus.data_en_i;
        // a pixel coincident with the vsync edge already belongs to row 0
        row_cur = vs_rise ? '0 : row;
        in_rng  = col < CNT_W'(IMG_W);
        addr    = col[AW-1:0];
        fg      = |bus.bin_data_i;
        ncol[0] = in_rng & lb2[addr];
        ncol[1] = in_rng & lb1[addr];
        ncol[2] = in_rng & fg;
    end

    // line buffers carry no reset: row gating hides stale contents
    always_ff @(posedge clk) begin
        if (bus.data_en_i && in_rng) begin
            lb2[addr] <= lb1[addr];
            lb1[addr] <= fg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            col       <= '0;
            row       <= '0;
            win       <= '0;
            valid_win <= 1'b0;
            and_q     <= '0;
            v2        <= 1'b0;
            erode     <= 1'b0;
            vs_p      <= '0;
            hs_p      <= '0;
            de_p      <= '0;
        end else begin
            vs_d <= bus.vsync_i;
            de_d <= bus.data_en_i;

            if (!bus.data_en_i)
                col <= '0;
            else if (col != '1)
                col <= col + 1'b1;

            if (vs_rise)
                row <= '0;
            else if (de_fall && row != '1)
                row <= row + 1'b1;

            if (bus.data_en_i) begin
                for (int i = 0; i < 3; i++)
                    win[i] <= {ncol[i], win[i][2:1]};
            end
            valid_win <= bus.data_en_i && in_rng &&
                         row_cur >= CNT_W'(2) &&
                         col >= CNT_W'(2);

            for (int i = 0; i < 3; i++)
                and_q[i] <= &win[i];
            v2    <= valid_win;
            erode <= (&and_q) & v2;

            vs_p <= {vs_p[1:0], bus.vsync_i};
            hs_p <= {hs_p[1:0], bus.hsync_i};
            de_p <= {de_p[1:0], bus.data_en_i};
        end
    end

    assign bus.vsync_o      = vs_p[2];
    assign bus.hsync_o      = hs_p[2];
    assign bus.data_en_o    = de_p[2];
    assign bus.erode_data_o = (erode && de_p[2]) ? 16'hFFFF : 16'h0000;
endmodule
